uart_receiver: RTL
==================

# uart_receiver

Serial receive front end of the UART, the counterpart of the transmit path. It oversamples the serial line at 16x baud, recovers 8N1 frames (start, 8 data bits LSB first, one stop bit) and buffers received bytes in an 8-entry FIFO. The host side reads the FIFO through a show-ahead valid/read interface.

## Interface
- No parameters: 8 data bits, 16x oversampling and 8-entry FIFO depth are fixed.
- Clocking and reset: one clock; reset is synchronous and active-high.
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_tick  in  1  single-cycle enable at 16x the baud rate, from the shared baud generator.
- i_rx  in  1  asynchronous serial input; idles high.
- i_read  in  1  pops the FIFO head; ignored when o_valid=0.
- o_D  out  8  FIFO head byte; valid only while o_valid=1.
- o_valid  out  1  FIFO not empty.
- o_full  out  1  FIFO holds 8 bytes.
- o_frame_err  out  1  one-cycle pulse when the stop bit samples low.
- o_overrun  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- Input sync: i_rx passes through two flops, both reset to 1. All decisions use the synchronized value `rx_s`.
- Sample counter `cnt` (4 bits) advances only on i_tick. Bit counter `nb` (3 bits) counts data bits. Shift register `sh` (8 bits) collects data.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a tick with rx_s=0, go to START with cnt=0.
  - START: on each tick, cnt++. On the tick where cnt==7 (mid start bit):
    - rx_s=0: go to DATA with cnt=0, nb=0.
    - rx_s=1: glitch; return to IDLE with no output.
  - DATA: on each tick, cnt++. On the tick where cnt==15:
    - shift right, sh = {rx_s, sh[7:1]}, so the first bit received ends in bit 0.
    - nb++; after the 8th bit (nb==7 at that sample), go to STOP with cnt=0.
  - STOP: on the tick where cnt==15, sample rx_s, then go to IDLE.
    - rx_s=1: push sh into the FIFO.
    - rx_s=0: pulse o_frame_err and discard the byte.
- Sampling therefore lands near mid-bit for every data bit and the stop bit. Returning to IDLE at mid-stop-bit lets back-to-back frames be accepted.
- FIFO:
  - Storage: 8x8 array, 3-bit write/read pointers that wrap 7->0, and a 4-bit count (0..8).
  - o_valid = (count!=0); o_full = (count==8); o_D = mem[rd_ptr].
  - pop = i_read & o_valid.
  - push is accepted when count<8, or when count==8 and pop is asserted in the same cycle.
  - A push that cannot be accepted pulses o_overrun; the FIFO is unchanged.
  - Simultaneous accepted push and pop: both pointers advance and count is unchanged.
  - count==0 with a push and i_read in the same cycle: the push is accepted and the pop is ignored (o_valid was 0).
- Reset values:
  - FSM=IDLE; cnt, nb, sh, pointers and count = 0; sync flops = 1.
  - Outputs: o_valid=0, o_full=0, o_frame_err=0, o_overrun=0, o_D=0. The FIFO array is cleared to 0.
- Reset mid-frame aborts the frame with no push and no error pulse. Reception restarts only on a fresh falling edge after reset deasserts.

## Timing
- i_rx to rx_s: 2 clocks of synchronizer latency.
- Push is registered in the cycle of the stop-bit sample tick. o_valid rises on the following clock edge (1 clock after that tick).
- o_frame_err and o_overrun assert for exactly the one clock following the stop-bit sample tick.
- Pop: o_D and o_valid update on the clock edge after i_read; no read latency (show-ahead).
- Frame duration from the falling edge detect to the stop sample: 8 + 8x16 + 16 = 152 ticks, plus a 0..1 tick detection uncertainty.
- i_tick asserted for more than one cycle is counted on every asserted cycle; the baud generator guarantees single-cycle pulses.

## Test plan
- Single byte: i_tick every 4 clocks; send 0xA5 in 8N1 → after the stop sample, o_valid=1 and o_D=0xA5. Assert i_read for 1 cycle → o_valid=0.
- Glitch rejection: drive i_rx low for 4 ticks, then high → FSM returns to IDLE, o_valid stays 0, no error pulse.
- Framing error: send 0x3C with the stop bit held low → one-cycle o_frame_err pulse, o_valid stays 0. A following good 0x55 is then received correctly.
- Fill and overrun: send 0x00..0x08 back-to-back without reading → o_full=1 after 0x07, 0x08 dropped with an o_overrun pulse. Reads then return 0x00..0x07 in order, then o_valid=0.
- Full with simultaneous pop: with the FIFO full, assert i_read on the push cycle of byte 0x99 → no overrun, count stays 8, and 0x99 is read last.
- Reset mid-frame: assert i_rst for 1 cycle during the DATA state of 0xF0 → no push and no error. The next frame, 0x0F, is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampling 8N1 serial receiver with an 8-entry
// show-ahead receive FIFO. Frames are sampled at mid-bit; a good byte is
// pushed at the mid-stop-bit sample, a low stop bit raises a framing error.
module uart_receiver (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_rx,
  input  logic       i_read,
  output logic [7:0] o_D,
  output logic       o_valid,
  output logic       o_full,
  output logic       o_frame_err,
  output logic       o_overrun
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  // Synchronizer and frame recovery state
  logic       rx_meta_q;
  logic       rx_s_q;
  state_e     state_q;
  logic [3:0] cnt_q;
  logic [2:0] nb_q;
  logic [7:0] sh_q;
  logic       frame_err_q;

  // FIFO state
  logic [7:0] mem_q [8];
  logic [2:0] wr_ptr_q;
  logic [2:0] rd_ptr_q;
  logic [3:0] count_q;
  logic [3:0] count_d;
  logic       overrun_q;

  logic push;
  logic pop;
  logic push_ok;
  logic full;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; rx_s_q gets the old rx_meta_q here.
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame recovery FSM: start detect, mid-bit data sampling, stop check.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      nb_q        <= 3'd0;
      sh_q        <= 8'd0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (i_tick) begin
        unique case (state_q)
          ST_IDLE: begin
            if (!rx_s_q) begin
              state_q <= ST_START;
              cnt_q   <= 4'd0;
            end
          end
          ST_START: begin
            if (cnt_q == 4'd7) begin
              // Mid start bit: a high line here was only a glitch.
              cnt_q <= 4'd0;
              nb_q  <= 3'd0;
              state_q <= rx_s_q ? ST_IDLE : ST_DATA;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          ST_DATA: begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              sh_q <= {rx_s_q, sh_q[7:1]};
              nb_q <= nb_q + 3'd1;
              if (nb_q == 3'd7) begin
                state_q <= ST_STOP;
                cnt_q   <= 4'd0;
              end
            end
          end
          ST_STOP: begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              // Leave at mid stop bit so a back-to-back start edge is seen.
              state_q     <= ST_IDLE;
              frame_err_q <= ~rx_s_q;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // A good stop-bit sample pushes the assembled byte this very cycle.
  assign push    = i_tick && (state_q == ST_STOP) && (cnt_q == 4'd15) && rx_s_q;
  assign full    = (count_q == 4'd8);
  assign pop     = i_read && (count_q != 4'd0);
  assign push_ok = push && (!full || pop);

  // Occupancy next state from accepted push/pop.
  always_comb begin
    // NOTE: default assignment first so no path leaves count_d unassigned
    // and infers a latch.
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers and overrun flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the array is cleared on reset so the head byte reads 0 out of
      // reset; this costs a reset net on every storage flop.
      for (int i = 0; i < 8; i++) mem_q[i] <= 8'd0;
      wr_ptr_q  <= 3'd0;
      rd_ptr_q  <= 3'd0;
      count_q   <= 4'd0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push && !push_ok;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= sh_q;
        wr_ptr_q        <= wr_ptr_q + 3'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 3'd1;
      count_q <= count_d;
    end
  end

  assign o_D         = mem_q[rd_ptr_q];
  assign o_valid     = (count_q != 4'd0);
  assign o_full      = full;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule
